// File: rtl/disp_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_arb_pkg
// Purpose  : Shared types and helpers for the display-sharing arbiter:
//            FSM state encoding, 1 ms divider constant and the round-robin
//            priority search used to pick the next owner.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package disp_arb_pkg;

  // Largest supported requester count; indices are 3 bits wide.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    OPEN = 2'd2
  } state_t;

  // Number of clk cycles in one millisecond.
  function automatic int ms_cycles(input int clk_in_mhz);
    return clk_in_mhz * 1000;
  endfunction

  // First set bit of req at or above start, wrapping modulo n.
  // Result is only meaningful when req has at least one bit set below n.
  function automatic logic [2:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] start,
                                         input int         n);
    logic [2:0] idx;
    logic [2:0] pos;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      pos = 3'((int'(start) + i) % n);
      if (!found && (i < n) && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage : disp_arb_pkg
`default_nettype wire

// File: rtl/disp_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_share_arbiter_if
// Purpose  : Bundle between the status sources and the display arbiter.
// Signals  : req_i      - level request per source
//            led_pat_i  - per-source LED pattern, source k at [8k+7:8k]
//            seg_pat_i  - per-source segment pattern, same packing
//            gnt_o      - one-hot registered grant
//            owner_vld_o- a grant is active
//            led_o/seg_o- polarity-corrected pin values
// Modports : master (sources side), slave (arbiter side)
// Revision : 1.0 - initial release
// ============================================================================
interface disp_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ*8-1:0] led_pat_i;
  logic [NUM_REQ*8-1:0] seg_pat_i;
  logic [NUM_REQ-1:0]   gnt_o;
  logic                 owner_vld_o;
  logic [7:0]           led_o;
  logic [7:0]           seg_o;

  modport master (
    output req_i, led_pat_i, seg_pat_i,
    input  gnt_o, owner_vld_o, led_o, seg_o
  );

  modport slave (
    input  req_i, led_pat_i, seg_pat_i,
    output gnt_o, owner_vld_o, led_o, seg_o
  );
endinterface : disp_share_arbiter_if
`default_nettype wire

// File: rtl/disp_share_arbiter_ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ms_tick_gen
// Purpose  : Free-running 1 ms strobe, one clk cycle wide, every
//            CLK_IN_MHZ*1000 cycles. Only rst_i restarts the period.
// Ports    : clk_i  - system clock
//            rst_i  - synchronous active-high reset
//            tick_o - 1 ms strobe
// Revision : 1.0 - initial release
// ============================================================================
module ms_tick_gen
  import disp_arb_pkg::*;
#(
  parameter int CLK_IN_MHZ = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int            MS_CYC = ms_cycles(CLK_IN_MHZ);
  localparam int            CNT_W  = $clog2(MS_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MS_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Strobe on the last count of each period; sampled by the next edge.
  assign tick_o = (cnt == LAST);

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/disp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disp_share_arbiter
// Purpose  : Round-robin owner selection for the shared LED bank and
//            seven-segment display, with a minimum ownership hold counted in
//            1 ms ticks, an idle pattern when nobody requests, and output
//            polarity correction.
// Ports    : clk_i - system clock
//            rst_i - synchronous active-high reset
//            bus   - disp_share_arbiter_if.slave (requests, patterns, grant,
//                    owner valid, LED and segment pins)
// Revision : 1.0 - initial release
// ============================================================================
module disp_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         CLK_IN_MHZ   = 100,
  parameter int         HOLD_MS      = 250,
  parameter logic       LED_POLARITY = 1'b1,
  parameter logic [7:0] IDLE_LED     = 8'h00,
  parameter logic [7:0] IDLE_SEG     = 8'h40
) (
  input  logic               clk_i,
  input  logic               rst_i,
  disp_share_arbiter_if.slave bus
);

  localparam int              HOLD_W   = (HOLD_MS < 2) ? 1 : $clog2(HOLD_MS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_MS);
  // Final XOR mask: all ones inverts the pins for active-low boards.
  localparam logic [7:0]      POL_MASK = {8{~LED_POLARITY}};

  state_t             state, state_n;
  logic [2:0]         owner, owner_n;
  logic               vld, vld_n;
  logic [NUM_REQ-1:0] gnt, gnt_n;
  logic [2:0]         rr_ptr, rr_ptr_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic               tick;

  logic [7:0] req_ext;
  logic [7:0] owner_bit;
  logic [7:0] others;
  logic [2:0] cand;
  logic       owner_req;
  logic       do_grant;
  logic       do_idle;

  logic [7:0] led_arr [0:MAX_REQ-1];
  logic [7:0] seg_arr [0:MAX_REQ-1];
  logic [7:0] led_r;
  logic [7:0] seg_r;

  ms_tick_gen #(
    .CLK_IN_MHZ (CLK_IN_MHZ)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Candidate search excludes the current owner, so in IDLE it covers all
  // requests and in HELD/OPEN it yields the next requester after the owner
  // (rr_ptr is always owner+1 while a grant is active).
  assign req_ext   = 8'(bus.req_i);
  assign owner_bit = vld ? (8'b1 << owner) : 8'h00;
  assign others    = req_ext & ~owner_bit;
  assign cand      = rr_next(others, rr_ptr, NUM_REQ);
  assign owner_req = vld & req_ext[owner];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= 3'd0;
      vld      <= 1'b0;
      gnt      <= '0;
      rr_ptr   <= 3'd0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      vld      <= vld_n;
      gnt      <= gnt_n;
      rr_ptr   <= rr_ptr_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    vld_n    = vld;
    gnt_n    = gnt;
    rr_ptr_n = rr_ptr;
    hold_n   = hold_cnt;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    case (state)
      IDLE: begin
        if (|others) do_grant = 1'b1;
      end
      HELD: begin
        // Release always wins over the hold; only preemption is blocked.
        if (!owner_req) begin
          if (|others) do_grant = 1'b1;
          else         do_idle  = 1'b1;
        end else if (tick) begin
          if (hold_cnt <= HOLD_W'(1)) begin
            hold_n  = '0;
            state_n = OPEN;
          end else begin
            hold_n = hold_cnt - HOLD_W'(1);
          end
        end
      end
      OPEN: begin
        if (!owner_req) begin
          if (|others) do_grant = 1'b1;
          else         do_idle  = 1'b1;
        end else if (|others) begin
          do_grant = 1'b1;
        end
      end
      default: begin
        do_idle = 1'b1;
      end
    endcase

    // A grant replaces the old one-hot outright, so there is never an
    // all-zero or two-hot cycle at a handover.
    if (do_grant) begin
      owner_n  = cand;
      vld_n    = 1'b1;
      rr_ptr_n = (int'(cand) == NUM_REQ - 1) ? 3'd0 : cand + 3'd1;
      hold_n   = HOLD_LD;
      state_n  = (HOLD_MS == 0) ? OPEN : HELD;
      for (int k = 0; k < NUM_REQ; k++) begin
        gnt_n[k] = (cand == 3'(k));
      end
    end

    if (do_idle) begin
      state_n = IDLE;
      vld_n   = 1'b0;
      gnt_n   = '0;
      hold_n  = '0;
    end
  end

  // Unpack the source patterns into fixed 8-entry tables so the owner index
  // selects directly; unused slots read as zero.
  for (genvar k = 0; k < MAX_REQ; k++) begin : g_unpack
    if (k < NUM_REQ) begin : g_used
      assign led_arr[k] = bus.led_pat_i[8*k +: 8];
      assign seg_arr[k] = bus.seg_pat_i[8*k +: 8];
    end else begin : g_unused
      assign led_arr[k] = 8'h00;
      assign seg_arr[k] = 8'h00;
    end
  end

  // Display follows the registered owner, so new data lands one cycle
  // after gnt_o changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_r <= IDLE_LED ^ POL_MASK;
      seg_r <= IDLE_SEG ^ POL_MASK;
    end else begin
      led_r <= (vld ? led_arr[owner] : IDLE_LED) ^ POL_MASK;
      seg_r <= (vld ? seg_arr[owner] : IDLE_SEG) ^ POL_MASK;
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.owner_vld_o = vld;
  assign bus.led_o       = led_r;
  assign bus.seg_o       = seg_r;

endmodule : disp_share_arbiter
`default_nettype wire

// File: tb/tb_disp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_share_arbiter
// Purpose  : Directed self-checking bench for disp_share_arbiter. Three
//            instances: A (4 sources, 2 ms hold, active-high), B (4 sources,
//            no hold, active-low pins) and C (single source).
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_share_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ecnt;
  int   bad;

  disp_share_arbiter_if #(.NUM_REQ(4)) bus_a ();
  disp_share_arbiter_if #(.NUM_REQ(4)) bus_b ();
  disp_share_arbiter_if #(.NUM_REQ(1)) bus_c ();

  disp_share_arbiter #(
    .NUM_REQ(4), .CLK_IN_MHZ(1), .HOLD_MS(2), .LED_POLARITY(1'b1),
    .IDLE_LED(8'h00), .IDLE_SEG(8'h40)
  ) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));

  disp_share_arbiter #(
    .NUM_REQ(4), .CLK_IN_MHZ(1), .HOLD_MS(0), .LED_POLARITY(1'b0),
    .IDLE_LED(8'h00), .IDLE_SEG(8'h40)
  ) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  disp_share_arbiter #(
    .NUM_REQ(1), .CLK_IN_MHZ(1), .HOLD_MS(0), .LED_POLARITY(1'b1),
    .IDLE_LED(8'h00), .IDLE_SEG(8'h40)
  ) dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    ecnt   = 0;
    rst    = 1'b1;
    bus_a.req_i = '0; bus_a.led_pat_i = 32'h3CA51881; bus_a.seg_pat_i = 32'h4F5B063F;
    bus_b.req_i = '0; bus_b.led_pat_i = 32'h3CA51881; bus_b.seg_pat_i = 32'h4F5B063F;
    bus_c.req_i = '0; bus_c.led_pat_i = 8'h5A;        bus_c.seg_pat_i = 8'h12;

    // Reset
    repeat (3) step();
    chk("rst_a_gnt", 32'(bus_a.gnt_o), 32'h0);
    chk("rst_a_vld", 32'(bus_a.owner_vld_o), 32'h0);
    chk("rst_a_led", 32'(bus_a.led_o), 32'h00);
    chk("rst_a_seg", 32'(bus_a.seg_o), 32'h40);
    chk("rst_b_gnt", 32'(bus_b.gnt_o), 32'h0);
    chk("rst_b_led", 32'(bus_b.led_o), 32'hFF);
    chk("rst_b_seg", 32'(bus_b.seg_o), 32'hBF);
    chk("rst_c_gnt", 32'(bus_c.gnt_o), 32'h0);
    ecnt = 0;   // edge 0 = last reset edge; ticks land on edges 1000, 2000
    rst  = 1'b0;

    // Single request on source 2
    bus_a.req_i = 4'b0100;
    step();
    chk("single_gnt", 32'(bus_a.gnt_o), 32'b0100);
    chk("single_vld", 32'(bus_a.owner_vld_o), 32'h1);
    chk("single_led_lag", 32'(bus_a.led_o), 32'h00);
    step();
    chk("single_led", 32'(bus_a.led_o), 32'hA5);
    chk("single_seg", 32'(bus_a.seg_o), 32'h5B);
    bus_a.led_pat_i[23:16] = 8'h77;
    step();
    chk("pat_follow", 32'(bus_a.led_o), 32'h77);

    // Release with no other request -> idle, idle pattern one cycle later
    bus_a.req_i = 4'b0000;
    step();
    chk("rel_idle_gnt", 32'(bus_a.gnt_o), 32'h0);
    chk("rel_idle_vld", 32'(bus_a.owner_vld_o), 32'h0);
    chk("rel_idle_led_lag", 32'(bus_a.led_o), 32'h77);
    step();
    chk("idle_led", 32'(bus_a.led_o), 32'h00);
    chk("idle_seg", 32'(bus_a.seg_o), 32'h40);

    // Hold then preempt: pointer is 3, so source 0 wins at edge 6
    bus_a.req_i = 4'b0001;
    step();
    chk("hold_gnt0", 32'(bus_a.gnt_o), 32'b0001);
    repeat (10) step();
    bus_a.req_i = 4'b1001;
    bad = 0;
    while (ecnt < 2000) begin
      step();
      if (bus_a.gnt_o !== 4'b0001) bad++;
    end
    chk("hold_kept", 32'(bad), 32'h0);
    step();
    chk("preempt_gnt", 32'(bus_a.gnt_o), 32'b1000);
    step();
    chk("preempt_led", 32'(bus_a.led_o), 32'h3C);

    // Early release mid-hold
    bus_a.req_i = 4'b0000;
    step();
    chk("idle_again", 32'(bus_a.gnt_o), 32'h0);
    bus_a.req_i = 4'b0010;
    step();
    chk("gnt1", 32'(bus_a.gnt_o), 32'b0010);
    bus_a.req_i = 4'b0110;
    step();
    chk("held_ignores", 32'(bus_a.gnt_o), 32'b0010);
    bus_a.req_i = 4'b0100;
    step();
    chk("early_release", 32'(bus_a.gnt_o), 32'b0100);
    bus_a.req_i = 4'b0010;
    step();
    chk("release_wrap", 32'(bus_a.gnt_o), 32'b0010);

    // Round-robin with no hold (B) and single source (C)
    bus_b.req_i = 4'b1111;
    bus_c.req_i = 1'b1;
    step();
    chk("rr_0", 32'(bus_b.gnt_o), 32'b0001);
    chk("one_gnt", 32'(bus_c.gnt_o), 32'h1);
    chk("one_vld", 32'(bus_c.owner_vld_o), 32'h1);
    step();
    chk("rr_1", 32'(bus_b.gnt_o), 32'b0010);
    chk("rr_led_inv0", 32'(bus_b.led_o), 32'h7E);
    chk("one_led", 32'(bus_c.led_o), 32'h5A);
    step();
    chk("rr_2", 32'(bus_b.gnt_o), 32'b0100);
    chk("rr_led_inv1", 32'(bus_b.led_o), 32'hE7);
    chk("rr_seg_inv1", 32'(bus_b.seg_o), 32'hF9);
    step();
    chk("rr_3", 32'(bus_b.gnt_o), 32'b1000);
    chk("one_keep", 32'(bus_c.gnt_o), 32'h1);
    step();
    chk("rr_wrap", 32'(bus_b.gnt_o), 32'b0001);
    bus_b.req_i = 4'b0000;
    bus_c.req_i = 1'b0;
    step();
    chk("rr_drop", 32'(bus_b.gnt_o), 32'h0);
    chk("one_drop", 32'(bus_c.gnt_o), 32'h0);

    // Reset mid-grant, then RR restarts from pointer 0
    chk("pre_rst_gnt", 32'(bus_a.gnt_o), 32'b0010);
    bus_a.req_i = 4'b1010;
    rst = 1'b1;
    step();
    chk("midrst_gnt", 32'(bus_a.gnt_o), 32'h0);
    chk("midrst_vld", 32'(bus_a.owner_vld_o), 32'h0);
    chk("midrst_led", 32'(bus_a.led_o), 32'h00);
    chk("midrst_seg", 32'(bus_a.seg_o), 32'h40);
    rst = 1'b0;
    step();
    chk("rr_after_rst", 32'(bus_a.gnt_o), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_disp_share_arbiter
`default_nettype wire

// File: doc/disp_share_arbiter.md
Name: disp_share_arbiter

Overview:
- Shares the board's single LED bank and seven-segment display between NUM_REQ status sources, e.g. the board-check pattern, an error reporter and a heartbeat.
- Grants one owner at a time, round-robin, with a minimum ownership hold in milliseconds so the display does not flicker between sources.
- The muxed, polarity-corrected pattern feeds the board pins in place of a single fixed driver.
- Falls back to a programmable idle pattern when nobody requests.

Parameters:
- NUM_REQ, 4: number of requesters, 1..8.
- CLK_IN_MHZ, 100: clock frequency in MHz; sets the 1 ms tick divider (CLK_IN_MHZ*1000 cycles).
- HOLD_MS, 250: minimum ownership before the owner can be preempted; 0 = no hold.
- LED_POLARITY, 1'b1: 1 = active-high pins; 0 = invert led_o and seg_o at the output.
- IDLE_LED, 8'h00: logical LED pattern shown with no owner.
- IDLE_SEG, 8'h40: logical segment pattern shown with no owner (dash).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- req_i  input  NUM_REQ  level request per source
- led_pat_i  input  NUM_REQ*8  per-source LED pattern, source k at [8k+7:8k]
- seg_pat_i  input  NUM_REQ*8  per-source segment pattern, same packing
- gnt_o  output  NUM_REQ  one-hot grant, registered
- owner_vld_o  output  1  a grant is active
- led_o  output  8  polarity-corrected LED pins
- seg_o  output  8  polarity-corrected segment pins

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- Reset values: state=IDLE, gnt_o=0, owner_vld_o=0, RR pointer=0, hold and tick counters=0. led_o=IDLE_LED and seg_o=IDLE_SEG after polarity correction (inverted when LED_POLARITY=0).
- Tick: a 1 ms tick strobe pulses for one cycle every CLK_IN_MHZ*1000 cycles. It free-runs and is reset only by rst_i.
- State IDLE:
  - If any req_i is set, grant the first set bit searching from the RR pointer upward with wrap.
  - gnt_o rises on the next edge (1-cycle latency). Hold counter loads HOLD_MS. Go to HELD, or to OPEN if HOLD_MS=0.
- State HELD:
  - Hold counter decrements on each tick; at 0, go to OPEN.
  - Other requests are ignored in HELD.
- State OPEN:
  - If any other req_i is set, regrant to the next requester after the owner (RR, wrap). Reload hold, go to HELD.
  - Otherwise keep the owner.
- Owner release: if the owner's req_i drops in HELD or OPEN, hand over the same edge to the next RR requester, or go to IDLE if none. The hold protects against preemption only, not release.
- Handover: gnt_o never has two bits set. A handover is a direct one-hot swap with no idle gap.
- RR pointer: set to owner+1 (mod NUM_REQ) on every new grant.
- Data path: led_o and seg_o are registered every cycle from the current gnt_o owner's pattern, or the IDLE pattern if owner_vld_o=0.
  - Display lags the pattern inputs by 1 cycle.
  - After a grant change, the new owner's data appears 1 cycle after gnt_o changes.
- Polarity: applied as a final XOR, so logical 1 = lit.
- NUM_REQ=1: the single source keeps the grant while req_i is held; no preemption is possible.
- Reset mid-grant: everything returns to reset values on the next edge, regardless of requests.
- Requests are assumed synchronous to clk_i; synchronising them is the caller's job.

Decomposition:
- Package disp_arb_pkg holds:
  - state enum (IDLE, HELD, OPEN)
  - ms_cycles(CLK_IN_MHZ) constant function
  - round-robin next-index function (priority search with wrap)
- Sub-module ms_tick_gen (CLK_IN_MHZ): free-running 1 ms strobe with synchronous active-high reset. Reusable by other board-check blocks.

Test Plan (CLK_IN_MHZ=1, HOLD_MS=2, NUM_REQ=4 unless stated):
- Reset: assert rst_i 3 cycles -> gnt_o=0, owner_vld_o=0, led_o=8'h00, seg_o=8'h40. With LED_POLARITY=0 -> led_o=8'hFF, seg_o=8'hBF.
- Single request: req_i=4'b0100, led_pat[2]=8'hA5 -> gnt_o=4'b0100 one cycle later, led_o=8'hA5 the cycle after. Pattern changes propagate in 1 cycle.
- Hold then preempt: source 0 granted, source 3 requests at cycle +10. gnt_o stays 4'b0001 for 2 ms (2000 cycles, tick-aligned), then swaps to 4'b1000 with no zero cycle.
- Round-robin: req_i=4'b1111 held, HOLD_MS=0 -> grants rotate 0,1,2,3,0 on successive regrants.
- Early release: owner 1 drops req mid-hold with req_i[2] set -> gnt_o=4'b0100 next edge. With no other request -> IDLE and idle pattern 1 cycle after gnt_o=0.
- Reset mid-grant: rst_i asserted while gnt_o=4'b0010 and req_i set -> all outputs at reset values next edge. After release, regrant follows RR from pointer 0.
